// File: rtl/console_writer_if.sv
// Byte-stream input and vram write bus of the console writer.
// master = console_writer side, slave = byte source / vram side.
interface console_writer_if #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 7
);
  logic                char_valid;
  logic                char_ready;
  logic [7:0]          char_byte;
  logic                vram_write_valid;
  logic                vram_write_ready;
  logic [ROW_BITS-1:0] vram_write_row;
  logic [COL_BITS-1:0] vram_write_col;
  logic [7:0]          vram_write_char;

  modport master (
    input  char_valid, char_byte, vram_write_ready,
    output char_ready, vram_write_valid, vram_write_row, vram_write_col, vram_write_char
  );

  modport slave (
    output char_valid, char_byte, vram_write_ready,
    input  char_ready, vram_write_valid, vram_write_row, vram_write_col, vram_write_char
  );
endinterface

// File: rtl/console_writer.sv
// Text console writer: turns a byte stream into vram write beats over a circular
// row buffer, handling cursor movement, line clears on newline and full clears.
module console_writer #(
  parameter int COLS     = 100,
  parameter int ROWS     = 30,
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 5,
  parameter int RAW_MODE = 0
) (
  input  logic                clk,
  input  logic                reset_low,
  console_writer_if.master    bus,
  output logic [ROW_BITS-1:0] top_row,
  output logic [ROW_BITS-1:0] cursor_row,
  output logic [COL_BITS-1:0] cursor_col
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR_LINE, CLEAR_ALL} state_t;

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [7:0]          SPACE    = 8'h20;

  state_t state_reg;

  // Rows wrap at ROWS, which need not be a power of two.
  function automatic logic [ROW_BITS-1:0] row_inc(input logic [ROW_BITS-1:0] r);
    return (r == LAST_ROW) ? '0 : r + 1'b1;
  endfunction

  logic                accept;
  logic                beat_done;
  logic                printable;
  logic                do_newline;
  logic [ROW_BITS-1:0] nl_row;
  logic [ROW_BITS-1:0] nl_top;

  assign bus.char_ready = (state_reg == IDLE);
  assign accept         = bus.char_valid && (state_reg == IDLE);
  assign beat_done      = bus.vram_write_valid && bus.vram_write_ready;
  assign printable      = (RAW_MODE != 0) ||
                          ((bus.char_byte >= 8'h20) && (bus.char_byte <= 8'h7E));

  // A newline comes either from a 0x0A byte or from writing the last column.
  assign do_newline = (accept && !printable && (bus.char_byte == 8'h0A)) ||
                      ((state_reg == WRITE) && beat_done && (cursor_col == LAST_COL));
  assign nl_row     = row_inc(cursor_row);
  assign nl_top     = (nl_row == top_row) ? row_inc(top_row) : top_row;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_reg            <= IDLE;
      bus.vram_write_valid <= 1'b0;
      bus.vram_write_row   <= '0;
      bus.vram_write_col   <= '0;
      bus.vram_write_char  <= '0;
      cursor_row           <= '0;
      cursor_col           <= '0;
      top_row              <= '0;
    end else if (do_newline) begin
      cursor_row           <= nl_row;
      cursor_col           <= '0;
      top_row              <= nl_top;
      state_reg            <= CLEAR_LINE;
      bus.vram_write_valid <= 1'b1;
      bus.vram_write_row   <= nl_row;
      bus.vram_write_col   <= '0;
      bus.vram_write_char  <= SPACE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              state_reg            <= WRITE;
              bus.vram_write_valid <= 1'b1;
              bus.vram_write_row   <= cursor_row;
              bus.vram_write_col   <= cursor_col;
              bus.vram_write_char  <= bus.char_byte;
            end else begin
              case (bus.char_byte)
                8'h0D: cursor_col <= '0;
                8'h08: if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
                8'h0C: begin
                  state_reg            <= CLEAR_ALL;
                  bus.vram_write_valid <= 1'b1;
                  bus.vram_write_row   <= '0;
                  bus.vram_write_col   <= '0;
                  bus.vram_write_char  <= SPACE;
                end
                default: ;
              endcase
            end
          end
        end

        // Last-column completion is handled by the newline branch above.
        WRITE: begin
          if (beat_done) begin
            cursor_col           <= cursor_col + 1'b1;
            bus.vram_write_valid <= 1'b0;
            state_reg            <= IDLE;
          end
        end

        CLEAR_LINE: begin
          if (beat_done) begin
            if (bus.vram_write_col == LAST_COL) begin
              bus.vram_write_valid <= 1'b0;
              cursor_col           <= '0;
              state_reg            <= IDLE;
            end else begin
              bus.vram_write_col <= bus.vram_write_col + 1'b1;
            end
          end
        end

        CLEAR_ALL: begin
          if (beat_done) begin
            if (bus.vram_write_col != LAST_COL) begin
              bus.vram_write_col <= bus.vram_write_col + 1'b1;
            end else if (bus.vram_write_row != LAST_ROW) begin
              bus.vram_write_row <= bus.vram_write_row + 1'b1;
              bus.vram_write_col <= '0;
            end else begin
              bus.vram_write_valid <= 1'b0;
              cursor_row           <= '0;
              cursor_col           <= '0;
              top_row              <= '0;
              state_reg            <= IDLE;
            end
          end
        end

        default: begin
          state_reg            <= IDLE;
          bus.vram_write_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
